servo_command_scheduler: RTL and testbench

SERVO_COMMAND_SCHEDULER -- requirements
Module: servo_command_scheduler

---
 rtl/servo_command_scheduler.sv | 177 +++++++++++++++++
 tb/tb_servo_command_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_command_scheduler.sv
// rtl/servo_command_scheduler.sv - two-axis servo command scheduler with frame timing, slew and failsafe
//
// Purpose:
//   Accepts x/y target pairs through a valid/ready handshake and applies them to
//   the registered PWM positions once per servo frame. If no command arrives for
//   TIMEOUT_FRAMES frames while tracking, the scheduler enters failsafe and
//   returns both axes to CENTER_POS.
//
// Configuration:
//   SERVO_SLEW_LIMIT_EN  defined   -> each axis moves at most SLEW_STEP per frame
//                        undefined -> each axis jumps straight to its target
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cmd_valid    in   x/y target pair presented
//   cmd_ready    out  command can be accepted this cycle (low on last frame tick and in reset)
//   cmd_x/cmd_y  in   10-bit commanded positions (clamped to MAX_POS)
//   x_pwm/y_pwm  out  registered positions to the PWM generator
//   frame_start  out  one-cycle pulse in the cycle after each frame edge
//   timeout      out  high while in failsafe

module servo_command_scheduler #(
    parameter int FRAME_TICKS    = 1000000,
    parameter int SLEW_STEP      = 8,
    parameter int TIMEOUT_FRAMES = 25,
    parameter int CENTER_POS     = 512,
    parameter int MAX_POS        = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    output logic [9:0] x_pwm,
    output logic [9:0] y_pwm,
    output logic       frame_start,
    output logic       timeout
);

    localparam int CNT_W  = $clog2(FRAME_TICKS);
    localparam int IDLE_W = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(FRAME_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_FRAMES - 1);
    localparam logic [9:0]        CENTER    = 10'(CENTER_POS);
    localparam logic [9:0]        MAXP      = 10'(MAX_POS);

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        TRACK    = 2'd1,
        FAILSAFE = 2'd2
    } stateType;

    stateType          state;
    stateType          nextState;
    logic [CNT_W-1:0]  frameCnt;
    logic [IDLE_W-1:0] idleCnt;
    logic              acceptSeen;   // an accept happened since the previous frame edge
    logic [9:0]        targetX;
    logic [9:0]        targetY;
    logic [9:0]        nextX;
    logic [9:0]        nextY;
    logic              frameEdge;
    logic              accept;
    logic              idleExpire;
    logic              forceCenter;

    function automatic logic [9:0] clampPos(input logic [9:0] pos);
        return (pos > MAXP) ? MAXP : pos;
    endfunction

`ifdef SERVO_SLEW_LIMIT_EN
    // 11-bit intermediates keep cur +/- step from wrapping; targets never
    // exceed MAX_POS, so stepping toward them stays inside 0..MAX_POS.
    function automatic logic [9:0] slewTo(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] cur11;
        logic [10:0] tgt11;
        logic [10:0] step11;
        cur11  = {1'b0, cur};
        tgt11  = {1'b0, tgt};
        step11 = 11'(SLEW_STEP);
        if (tgt11 >= cur11) begin
            if (tgt11 - cur11 <= step11) return tgt;
            return 10'(cur11 + step11);
        end
        if (cur11 - tgt11 <= step11) return tgt;
        return 10'(cur11 - step11);
    endfunction

    assign nextX = slewTo(x_pwm, targetX);
    assign nextY = slewTo(y_pwm, targetY);
`else
    assign nextX = targetX;
    assign nextY = targetY;
`endif

    // The frame edge is the last tick; refusing commands there means an accept
    // never coincides with the edge that consumes the targets.
    assign frameEdge = (frameCnt == LAST_TICK);
    assign cmd_ready = rst_n & ~frameEdge;
    assign accept    = cmd_valid & cmd_ready;

    // This frame edge completes the TIMEOUT_FRAMES-th consecutive idle frame.
    assign idleExpire = (state == TRACK) && frameEdge && !acceptSeen && (idleCnt == IDLE_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_CMD;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            WAIT_CMD: if (accept) nextState = TRACK;
            TRACK:    if (idleExpire) nextState = FAILSAFE;
            FAILSAFE: if (accept) nextState = TRACK;
            default:  nextState = WAIT_CMD;
        endcase
    end

    // Output logic
    always_comb begin
        timeout     = 1'b0;
        forceCenter = 1'b0;
        case (state)
            TRACK:    forceCenter = idleExpire;
            FAILSAFE: timeout     = 1'b1;
            default:  ;
        endcase
    end

    // Frame timing, targets, idle tracking and PWM positions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt    <= '0;
            frame_start <= 1'b0;
            idleCnt     <= '0;
            acceptSeen  <= 1'b0;
            targetX     <= CENTER;
            targetY     <= CENTER;
            x_pwm       <= CENTER;
            y_pwm       <= CENTER;
        end else begin
            frameCnt    <= frameEdge ? '0 : frameCnt + 1'b1;
            frame_start <= frameEdge;

            if (frameEdge) begin
                x_pwm      <= nextX;
                y_pwm      <= nextY;
                acceptSeen <= 1'b0;
                if (state == TRACK && !acceptSeen) begin
                    idleCnt <= idleCnt + 1'b1;
                end
            end

            if (forceCenter) begin
                targetX <= CENTER;
                targetY <= CENTER;
            end

            if (accept) begin
                targetX    <= clampPos(cmd_x);
                targetY    <= clampPos(cmd_y);
                acceptSeen <= 1'b1;
                idleCnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_servo_command_scheduler.sv
// tb/tb_servo_command_scheduler.sv - randomized and directed bench for servo_command_scheduler
module tb_servo_command_scheduler;

    localparam int FT   = 16;
    localparam int STEP = 8;
    localparam int TO   = 3;
    localparam int CEN  = 512;
    localparam int MAXP = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x = '0;
    logic [9:0] cmd_y = '0;
    logic [9:0] x_pwm;
    logic [9:0] y_pwm;
    logic       frame_start;
    logic       timeout;

    servo_command_scheduler #(
        .FRAME_TICKS(FT),
        .SLEW_STEP(STEP),
        .TIMEOUT_FRAMES(TO),
        .CENTER_POS(CEN),
        .MAX_POS(MAXP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x(cmd_x),
        .cmd_y(cmd_y),
        .x_pwm(x_pwm),
        .y_pwm(y_pwm),
        .frame_start(frame_start),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: ticks since reset modulo FT, targets, outputs, mode
    // (0 waiting, 1 tracking, 2 failsafe), consecutive idle frames.
    int mPhase, mTx, mTy, mOx, mOy, mIdle, mMode;
    bit mAccSince, mFs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int moveToward(input int o, input int t);
`ifdef SERVO_SLEW_LIMIT_EN
        int d = t - o;
        if (d >= -STEP && d <= STEP) return t;
        return (d > 0) ? o + STEP : o - STEP;
`else
        return t + 0 * o;
`endif
    endfunction

    function automatic int clampPos(input int v);
        return (v > MAXP) ? MAXP : v;
    endfunction

    task automatic modelReset();
        mPhase = 0; mTx = CEN; mTy = CEN; mOx = CEN; mOy = CEN;
        mIdle = 0; mMode = 0; mAccSince = 0; mFs = 0;
    endtask

    task automatic modelStep();
        bit isEdge;
        bit acc;
        if (!rst_n) begin
            modelReset();
        end else begin
            isEdge = (mPhase == FT - 1);
            acc    = cmd_valid && !isEdge;
            if (isEdge) begin
                mOx = moveToward(mOx, mTx);
                mOy = moveToward(mOy, mTy);
                if (mMode == 1) begin
                    if (!mAccSince) mIdle++;
                    if (mIdle >= TO) begin
                        mMode = 2; mTx = CEN; mTy = CEN;
                    end
                end
                mAccSince = 0;
            end
            mFs = isEdge;
            if (acc) begin
                mTx = clampPos(int'(cmd_x));
                mTy = clampPos(int'(cmd_y));
                mAccSince = 1; mIdle = 0; mMode = 1;
            end
            mPhase = (mPhase + 1) % FT;
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        check("x_pwm", 32'(x_pwm), mOx);
        check("y_pwm", 32'(y_pwm), mOy);
        check("frame_start", 32'(frame_start), 32'(mFs));
        check("timeout", 32'(timeout), 32'(mMode == 2));
        check("cmd_ready", 32'(cmd_ready), 32'(rst_n && mPhase != FT - 1));
    endtask

    task automatic send(input int x, input int y);
        cmd_valid = 1'b1; cmd_x = 10'(x); cmd_y = 10'(y);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic waitPhase(input int p);
        for (int i = 0; i < FT && mPhase != p; i++) step();
    endtask

    task automatic waitFs();
        int n = 0;
        do begin
            step();
            n++;
        end while (!mFs && n < 3 * FT);
        check("frame_start_within_bound", 32'(frame_start), 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int fsCount;
        int n;
        int dens;
        bit hit;

        modelReset();
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_x", 32'(x_pwm), 512);
        check("reset_y", 32'(y_pwm), 512);
        check("reset_ready", 32'(cmd_ready), 0);
        check("reset_timeout", 32'(timeout), 0);
        rst_n = 1'b1;

        // No commands: three frames, centred, never times out
        fsCount = 0;
        for (int i = 0; i < 3 * FT; i++) begin
            step();
            if (frame_start) fsCount++;
        end
        check("idle_frame_pulses", fsCount, 3);
        check("idle_timeout", 32'(timeout), 0);
        check("idle_x", 32'(x_pwm), 512);

        // Slew sequence / direct jump with clamp
        waitPhase(3);
        send(530, 500);
`ifdef SERVO_SLEW_LIMIT_EN
        waitFs(); check("slew1_x", 32'(x_pwm), 520); check("slew1_y", 32'(y_pwm), 504);
        waitFs(); check("slew2_x", 32'(x_pwm), 528); check("slew2_y", 32'(y_pwm), 500);
        waitFs(); check("slew3_x", 32'(x_pwm), 530); check("slew3_y", 32'(y_pwm), 500);
        waitFs(); check("slew4_x", 32'(x_pwm), 530); check("slew4_y", 32'(y_pwm), 500);
`else
        waitFs(); check("jump_x", 32'(x_pwm), 530); check("jump_y", 32'(y_pwm), 500);
        waitPhase(3);
        send(1023, 0);
        waitFs(); check("clamp_x", 32'(x_pwm), 1000); check("clamp_y", 32'(y_pwm), 0);
`endif

        // Valid held across the frame edge
        waitPhase(FT - 1);
        check("ready_last_tick", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_x = 10'd100; cmd_y = 10'd200;
        step();
        check("ready_after_wrap", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        waitFs();
`ifdef SERVO_SLEW_LIMIT_EN
        check("held_x", 32'(x_pwm), 522); check("held_y", 32'(y_pwm), 492);
`else
        check("held_x", 32'(x_pwm), 100); check("held_y", 32'(y_pwm), 200);
`endif

        // Timeout after three idle frames, return to centre, recovery
        doReset();
        waitPhase(3);
        send(600, 600);
        fsCount = 0; hit = 0;
        for (int i = 0; i < 10 * FT; i++) begin
            step();
            if (frame_start) fsCount++;
            if (timeout) begin hit = 1; break; end
        end
        check("timeout_reached", 32'(hit), 1);
        check("timeout_edge_count", fsCount, 4);
        check("timeout_with_frame_start", 32'(frame_start), 1);
`ifdef SERVO_SLEW_LIMIT_EN
        check("timeout_x", 32'(x_pwm), 544);
        waitFs(); check("failsafe_x", 32'(x_pwm), 536);
`else
        check("timeout_x", 32'(x_pwm), 600);
        waitFs(); check("failsafe_x", 32'(x_pwm), 512);
`endif
        waitPhase(5);
        send(700, 700);
        check("timeout_cleared", 32'(timeout), 0);

        // Reset in the middle of a slew
        doReset();
        waitPhase(3);
        send(700, 700);
        waitFs();
        waitFs();
        rst_n = 1'b0;
        #1;
        check("midreset_x", 32'(x_pwm), 512);
        check("midreset_y", 32'(y_pwm), 512);
        check("midreset_ready", 32'(cmd_ready), 0);
        check("midreset_timeout", 32'(timeout), 0);
        modelReset();
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 3 * FT);
        check("first_frame_after_reset", n, FT);

        // Randomized traffic with busy and quiet stretches and rare resets
        dens = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) dens = ($urandom_range(0, 1) == 0) ? 3 : 150;
            cmd_valid = ($urandom_range(0, dens) == 0);
            cmd_x = 10'($urandom_range(0, 1023));
            cmd_y = 10'($urandom_range(0, 1023));
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
